// File: rtl/lpif_tx_pkt_arbiter.sv
// Packet arbiter sharing the LPIF TX path between TLP and DLLP sources.
// Ports: clk/reset (async, low), tlp_*/dllp_* sources, lp_* registered output,
// pl_trdy/pl_link_up from PHY; perf counters when LPIF_TX_ARB_PERF_EN is defined.
module lpif_tx_pkt_arbiter #(
  parameter int DATA_W          = 512,
  parameter int MAX_DLLP_STREAK = 4,
  parameter int STREAK_W        = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pl_link_up,
  input  logic                tlp_valid,
  input  logic [DATA_W-1:0]   tlp_data,
  input  logic [DATA_W/8-1:0] tlp_bvalid,
  input  logic                tlp_end,
  output logic                tlp_ready,
  input  logic                dllp_valid,
  input  logic [DATA_W-1:0]   dllp_data,
  input  logic [DATA_W/8-1:0] dllp_bvalid,
  input  logic                dllp_end,
  output logic                dllp_ready,
  output logic                lp_irdy,
  output logic [DATA_W-1:0]   lp_data,
  output logic [DATA_W/8-1:0] lp_valid,
  output logic                lp_tlpstart,
  output logic                lp_tlpend,
  output logic                lp_dllpstart,
  output logic                lp_dllpend,
  input  logic                pl_trdy
`ifdef LPIF_TX_ARB_PERF_EN
  ,
  output logic [31:0]         tlp_pkt_cnt,
  output logic [31:0]         dllp_pkt_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int BV_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, TLP, DLLP} state_e;

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                lp_irdy_q, lp_irdy_d;
  logic [DATA_W-1:0]   lp_data_q, lp_data_d;
  logic [BV_W-1:0]     lp_valid_q, lp_valid_d;
  logic                lp_tlpstart_q, lp_tlpstart_d;
  logic                lp_tlpend_q, lp_tlpend_d;
  logic                lp_dllpstart_q, lp_dllpstart_d;
  logic                lp_dllpend_q, lp_dllpend_d;

  logic can_load, idle, streak_full;
  logic pick_dllp, pick_tlp, sel_tlp, sel_dllp;
  logic tlp_acc, dllp_acc;

  always_comb begin
    can_load    = !lp_irdy_q | pl_trdy;
    idle        = (state_q == IDLE);
    streak_full = (streak_q == STREAK_W'(MAX_DLLP_STREAK));
    // DLLP wins unless a waiting TLP has been passed over too often
    pick_dllp   = pl_link_up & dllp_valid & !(tlp_valid & streak_full);
    pick_tlp    = pl_link_up & tlp_valid & !pick_dllp;
    sel_tlp     = idle ? pick_tlp  : (state_q == TLP);
    sel_dllp    = idle ? pick_dllp : (state_q == DLLP);
    tlp_ready   = reset & can_load & sel_tlp;
    dllp_ready  = reset & can_load & sel_dllp;
    tlp_acc     = tlp_valid & tlp_ready;
    dllp_acc    = dllp_valid & dllp_ready;

    state_d        = state_q;
    streak_d       = streak_q;
    lp_irdy_d      = lp_irdy_q;
    lp_data_d      = lp_data_q;
    lp_valid_d     = lp_valid_q;
    lp_tlpstart_d  = lp_tlpstart_q;
    lp_tlpend_d    = lp_tlpend_q;
    lp_dllpstart_d = lp_dllpstart_q;
    lp_dllpend_d   = lp_dllpend_q;

    if (can_load) begin
      lp_irdy_d      = tlp_acc | dllp_acc;
      lp_tlpstart_d  = 1'b0;
      lp_tlpend_d    = 1'b0;
      lp_dllpstart_d = 1'b0;
      lp_dllpend_d   = 1'b0;
      if (tlp_acc) begin
        lp_data_d     = tlp_data;
        lp_valid_d    = tlp_bvalid;
        lp_tlpstart_d = idle;
        lp_tlpend_d   = tlp_end;
      end
      if (dllp_acc) begin
        lp_data_d      = dllp_data;
        lp_valid_d     = dllp_bvalid;
        lp_dllpstart_d = idle;
        lp_dllpend_d   = dllp_end;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (tlp_acc & !tlp_end)   state_d = TLP;
        if (dllp_acc & !dllp_end) state_d = DLLP;
      end
      TLP:     if (tlp_acc & tlp_end)   state_d = IDLE;
      DLLP:    if (dllp_acc & dllp_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // streak only moves on the first beat of a packet
    if (idle & dllp_acc) begin
      if (!tlp_valid)       streak_d = '0;
      else if (!streak_full) streak_d = streak_q + 1'b1;
    end
    if (idle & tlp_acc) streak_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      streak_q       <= '0;
      lp_irdy_q      <= 1'b0;
      lp_data_q      <= '0;
      lp_valid_q     <= '0;
      lp_tlpstart_q  <= 1'b0;
      lp_tlpend_q    <= 1'b0;
      lp_dllpstart_q <= 1'b0;
      lp_dllpend_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      streak_q       <= streak_d;
      lp_irdy_q      <= lp_irdy_d;
      lp_data_q      <= lp_data_d;
      lp_valid_q     <= lp_valid_d;
      lp_tlpstart_q  <= lp_tlpstart_d;
      lp_tlpend_q    <= lp_tlpend_d;
      lp_dllpstart_q <= lp_dllpstart_d;
      lp_dllpend_q   <= lp_dllpend_d;
    end
  end

  assign lp_irdy      = lp_irdy_q;
  assign lp_data      = lp_data_q;
  assign lp_valid     = lp_valid_q;
  assign lp_tlpstart  = lp_tlpstart_q;
  assign lp_tlpend    = lp_tlpend_q;
  assign lp_dllpstart = lp_dllpstart_q;
  assign lp_dllpend   = lp_dllpend_q;

`ifdef LPIF_TX_ARB_PERF_EN
  logic [31:0] tlp_pkt_cnt_q, tlp_pkt_cnt_d;
  logic [31:0] dllp_pkt_cnt_q, dllp_pkt_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    tlp_pkt_cnt_d  = tlp_pkt_cnt_q + {31'd0, tlp_acc & tlp_end};
    dllp_pkt_cnt_d = dllp_pkt_cnt_q + {31'd0, dllp_acc & dllp_end};
    stall_cnt_d    = stall_cnt_q + {31'd0, lp_irdy_q & !pl_trdy};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tlp_pkt_cnt_q  <= '0;
      dllp_pkt_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      tlp_pkt_cnt_q  <= tlp_pkt_cnt_d;
      dllp_pkt_cnt_q <= dllp_pkt_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign tlp_pkt_cnt  = tlp_pkt_cnt_q;
  assign dllp_pkt_cnt = dllp_pkt_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule
